// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write bank.
package regfile_pkg;

  localparam int unsigned WIDTH    = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ZERO_REG = 31;

  typedef logic [WIDTH-1:0]  reg_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/decoder_5to32.sv
// 5-to-32 one-hot decoder: two 4:16 halves selected by the address MSB.
module decoder_5to32
  import regfile_pkg::*;
(
  input  logic        en,
  input  logic [4:0]  addr,
  output logic [31:0] out
);

  logic en_lo, en_hi;

  // The MSB picks which 4:16 half receives the enable.
  assign en_lo = en & ~addr[4];
  assign en_hi = en &  addr[4];

  for (genvar i = 0; i < 16; i++) begin : g_half
    localparam logic [3:0] Sel = 4'(i);
    assign out[i]      = en_lo & (addr[3:0] == Sel);
    assign out[16 + i] = en_hi & (addr[3:0] == Sel);
  end

endmodule

// File: rtl/regfile_write_bank.sv
// Write side of the register file: decoded one-hot enables and 31 writable 64-bit registers.
module regfile_write_bank
  import regfile_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  reg_addr_t                 wr_addr,
  input  reg_t                      wr_data,
  output logic [NUM_REGS*WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]       wr_onehot
);

  localparam logic [NUM_REGS-1:0] ZeroMask = NUM_REGS'(1) << ZERO_REG;

  logic [NUM_REGS-1:0] dec_out;

  decoder_5to32 u_decoder (
    .en   (wr_en),
    .addr (wr_addr),
    .out  (dec_out)
  );

  assign wr_onehot = dec_out & ~ZeroMask;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign regs_out[i*WIDTH +: WIDTH] = '0;
    end else begin : g_flop
      reg_t reg_d, reg_q;

      always_comb begin
        reg_d = reg_q;
        if (wr_onehot[i]) begin
          reg_d = wr_data;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign regs_out[i*WIDTH +: WIDTH] = reg_q;
    end
  end

endmodule
